// File: rtl/wb_host_bridge.sv
// Single-outstanding Wishbone master: turns a valid/ready host request into one
// Wishbone cycle and returns read data or an error on a valid/ready response channel.
module wb_host_bridge #(
  parameter int  WB_DATA_WIDTH  = 32,
  parameter int  WB_ADDR_WIDTH  = 32,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int WB_BYTE_SEL    = WB_DATA_WIDTH / 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  input  logic [WB_BYTE_SEL-1:0]   req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     rsp_timeout_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [WB_BYTE_SEL-1:0]   wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_stall_i
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the payload is stable while valid is high.

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                   state_q,       state_d;
  logic [CNT_W-1:0]         cnt_q,         cnt_d;
  logic                     wb_cyc_q,      wb_cyc_d;
  logic [WB_ADDR_WIDTH-1:0] wb_addr_q,     wb_addr_d;
  logic [WB_DATA_WIDTH-1:0] wb_data_q,     wb_data_d;
  logic [WB_BYTE_SEL-1:0]   wb_sel_q,      wb_sel_d;
  logic                     wb_we_q,       wb_we_d;
  logic                     rsp_valid_q,   rsp_valid_d;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;
  logic                     rsp_err_q,     rsp_err_d;
  logic                     rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_cyc_d      = wb_cyc_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_sel_d      = wb_sel_q;
    wb_we_d       = wb_we_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          wb_addr_d     = req_addr_i;
          wb_data_d     = req_data_i;
          wb_sel_d      = req_sel_i;
          wb_we_d       = req_we_i;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          cnt_d         = '0;
          // Misaligned requests never reach the bus; they are answered directly.
          if (req_addr_i[1:0] != 2'b00) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ACTIVE;
            wb_cyc_d  = 1'b1;
            rsp_err_d = 1'b0;
          end
        end
      end

      ST_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wb_err_i) begin
          state_d     = ST_RESP;
          wb_cyc_d    = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (wb_ack_i) begin
          state_d     = ST_RESP;
          wb_cyc_d    = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = wb_we_q ? '0 : wb_data_i;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = ST_RESP;
          wb_cyc_d      = 1'b0;
          cnt_d         = '0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_data_d    = '0;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_data_d    = '0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wb_cyc_q      <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_sel_q      <= '0;
      wb_we_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_sel_q      <= wb_sel_d;
      wb_we_q       <= wb_we_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // cyc and stb are one signal: a single-beat master never idles stb inside a cycle.
  assign req_ready_o   = (state_q == ST_IDLE) && wb_rst_i;
  assign wb_cyc_o      = wb_cyc_q;
  assign wb_stb_o      = wb_cyc_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign wb_sel_o      = wb_sel_q;
  assign wb_we_o       = wb_we_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Bench for wb_host_bridge: host driver, Wishbone RAM slave model with stall/no-ack/err
// modes, response scoreboard and directed plus random transactions.
module tb_wb_host_bridge;

  logic        clk;
  logic        wb_rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  wb_host_bridge #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_sel_i    (req_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_data_i    (wb_data_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .wb_stall_i   (wb_stall_i)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {timeout, err, data}
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  // slave model controls: 0 normal, 1 never respond, 2 err+ack together
  int          slv_mode   = 0;
  int          stall_left = 0;
  int          stb_cycles = 0;
  int          stab_err   = 0;
  bit          prev_cyc   = 0;
  bit          accepted   = 0;
  logic [68:0] snap;
  bit          rand_bp    = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- Wishbone RAM slave model (acts on negedge) ----------------
  always @(negedge clk) begin
    logic [5:0] idx;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      stb_cycles++;
      if (!prev_cyc) snap = {wb_we_o, wb_sel_o, wb_addr_o, wb_data_o};
      else if (snap !== {wb_we_o, wb_sel_o, wb_addr_o, wb_data_o}) stab_err++;
      prev_cyc = 1'b1;
      idx = wb_addr_o[7:2];
      if (stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left--;
      end else if (!accepted) begin
        accepted = 1'b1;
      end else if (slv_mode == 2) begin
        wb_err_i  = 1'b1;
        wb_ack_i  = 1'b1;
        wb_data_i = mem[idx];
      end else if (slv_mode == 0) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          mem[idx]  = merge(mem[idx], wb_data_o, wb_sel_o);
          wb_data_i = 32'h0BAD_F00D;
        end else begin
          wb_data_i = mem[idx];
        end
      end
    end else begin
      prev_cyc = 1'b0;
      accepted = 1'b0;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (wb_rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", {30'b0, rsp_timeout_o, rsp_err_o, rsp_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp", {30'b0, rsp_timeout_o, rsp_err_o, rsp_data_o}, {30'b0, e});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) rsp_ready_i = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, input logic [33:0] exp, input bit push);
    int n;
    @(negedge clk);
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = data;
    req_sel_i   = sel;
    req_valid_i = 1'b1;
    if (push) exp_q.push_back(exp);
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_accept", req_ready_o, 1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], data, sel);
    send(1'b1, addr, data, sel, 34'h0, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr);
    send(1'b0, addr, 32'h0, 4'hF, {2'b00, ref_mem[addr[7:2]]}, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    wb_rst_i    = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_sel_i   = '0;
    rsp_ready_i = 1'b1;
    wb_data_i   = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    wb_stall_i  = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready_o, 0);
    check_eq("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    check_eq("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);
    check_eq("rst_rsp_data", rsp_data_o, 0);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check_eq("post_rst_req_ready", req_ready_o, 1);

    // write DEADBEEF then read back, with latency profile on the write
    stb_cycles = 0;
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    check_eq("lat_c1", {wb_stb_o, wb_cyc_o, rsp_valid_o}, 3'b110);
    check_eq("lat_c1_addr", wb_addr_o, 32'h10);
    @(posedge clk); #1;
    check_eq("lat_c2", {wb_stb_o, wb_cyc_o, rsp_valid_o}, 3'b110);
    @(posedge clk); #1;
    check_eq("lat_c3", {wb_stb_o, wb_cyc_o, rsp_valid_o}, 3'b001);
    wait_done();
    check_eq("wr_stb_cycles", stb_cycles, 2);
    stb_cycles = 0;
    do_read(32'h10);
    wait_done();
    check_eq("rd_stb_cycles", stb_cycles, 2);

    // partial byte write
    mem[5]     = 32'h1122_3344;
    ref_mem[5] = 32'h1122_3344;
    do_write(32'h14, 32'h0000_00AA, 4'h1);
    do_read(32'h14);
    wait_done();
    check_eq("sel_mem", mem[5], 32'h1122_33AA);

    // misaligned read: answered next cycle with no bus cycle
    stb_cycles = 0;
    send(1'b0, 32'h13, 32'h0, 4'hF, {2'b01, 32'h0}, 1'b1);
    check_eq("misalign_lat", {rsp_valid_o, rsp_err_o, rsp_timeout_o, wb_cyc_o}, 4'b1100);
    wait_done();
    check_eq("misalign_no_cyc", stb_cycles, 0);

    // timeout: slave never responds
    slv_mode   = 1;
    stb_cycles = 0;
    send(1'b0, 32'h20, 32'h0, 4'hF, {2'b11, 32'h0}, 1'b1);
    wait_done();
    check_eq("timeout_stb_cycles", stb_cycles, 8);
    slv_mode = 0;

    // stall for three cycles, then ack; fields must stay constant
    stall_left = 3;
    stb_cycles = 0;
    stab_err   = 0;
    do_write(32'h24, 32'h5A5A_1234, 4'hF);
    wait_done();
    check_eq("stall_stb_cycles", stb_cycles, 5);
    check_eq("stall_stable", stab_err, 0);
    do_read(32'h24);
    wait_done();

    // err and ack together, response held back for five cycles
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    slv_mode = 2;
    send(1'b0, 32'h18, 32'h0, 4'hF, {2'b01, 32'h0}, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_rsp_seen", rsp_valid_o, 1);
    slv_mode   = 0;
    req_we_i   = 1'b0;
    req_addr_i = 32'h28;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_state", {rsp_valid_o, req_ready_o, wb_cyc_o, wb_stb_o}, 4'b1000);
    end
    req_valid_i = 1'b0;
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    wait_done();

    // reset while stb is high
    slv_mode = 1;
    send(1'b0, 32'h30, 32'h0, 4'hF, 34'h0, 1'b0);
    @(negedge clk);
    check_eq("abort_pre_stb", wb_stb_o, 1);
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    check_eq("abort_rsp_valid", rsp_valid_o, 0);
    check_eq("abort_req_ready", req_ready_o, 0);
    @(negedge clk);
    wb_rst_i = 1'b1;
    slv_mode = 0;
    stb_cycles = 0;
    do_write(32'h30, 32'hCAFE_F00D, 4'hF);
    do_read(32'h30);
    wait_done();
    check_eq("post_abort_stb_cycles", stb_cycles, 4);

    // random traffic with response back-pressure
    rand_bp = 1;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(1, 15)));
      else
        do_read(a);
    end
    wait_done();
    rand_bp = 0;
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    check_eq("final_stable", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
